hdb3_decode: RTL and testbench

HDB3_DECODE -- requirements
Module: hdb3_decode

---
 rtl/hdb3_pkg.sv | 28 ++
 rtl/hdb3_v_detect.sv | 40 ++++
 rtl/hdb3_decode.sv | 124 ++++++++++++
 tb/tb_hdb3_decode.sv | 138 +++++++++++++
 4 files changed

// File: rtl/hdb3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hdb3_pkg
//  Description : Shared HDB3 line-code constants and helpers used by the
//                encoder and decoder paths.
//  Revision    : 1.0 - initial release
// ============================================================================
package hdb3_pkg;

    // Ternary symbol encoding on the 2-bit code bus
    localparam logic [1:0] HDB3_ZERO = 2'b00;
    localparam logic [1:0] HDB3_POS  = 2'b01;
    localparam logic [1:0] HDB3_NEG  = 2'b10;
    localparam logic [1:0] HDB3_ILL  = 2'b11;

    // Substitution length, equal to the decoder pipeline depth
    localparam int HDB3_RUN = 4;

    // Width of small counters that saturate at HDB3_RUN
    localparam int FILL_W = 3;

    // True for a positive or negative mark; zero and illegal are not marks
    function automatic logic is_mark(input logic [1:0] code);
        return (code == HDB3_POS) || (code == HDB3_NEG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdb3_v_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hdb3_v_detect
//  Description : Mark polarity tracker and violation (V) classifier. A mark is
//                a V when a previous mark has been seen and it repeats the
//                polarity of that mark. Outputs are per-cycle combinational
//                flags for the registered pipeline in the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdb3_v_detect
    import hdb3_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_code,
    output logic       o_mark,
    output logic       o_is_v
);

    logic r_seen;     // a mark has been observed since reset
    logic r_pol;      // polarity of the last mark, 1 = positive
    logic w_pos;

    assign w_pos  = (i_code == HDB3_POS);
    assign o_mark = is_mark(i_code);
    assign o_is_v = o_mark & r_seen & (w_pos == r_pol);

    // Track the polarity of the most recent mark; illegal codes are ignored
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seen <= 1'b0;
            r_pol  <= 1'b0;
        end else if (o_mark) begin
            r_seen <= 1'b1;
            r_pol  <= w_pos;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hdb3_decode.sv
`default_nettype none
// ============================================================================
//  Module      : hdb3_decode
//  Description : HDB3 line decoder. Marks become 1, zeros and illegal codes
//                become 0, and every V mark clears itself plus the three
//                preceding positions in a 4-deep delay line, which undoes
//                both 000V and B00V substitutions. Latency is 4 clocks.
//                Macro HDB3_DECODE_ERR_EN enables line-code error detection
//                (illegal code, four zeros in a row, back-to-back V marks);
//                without it o_err and o_err_cnt are constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdb3_decode
    import hdb3_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_hdb3_code,
    output logic                 o_data,
    output logic                 o_valid,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(HDB3_RUN);

    logic              w_mark;
    logic              w_is_v;
    logic              r_s0;
    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic [FILL_W-1:0] r_fill;
    logic              w_full;

    hdb3_v_detect u_v_detect (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_code (i_hdb3_code),
        .o_mark (w_mark),
        .o_is_v (w_is_v)
    );

    // Pipeline is full once HDB3_RUN symbols have been sampled since reset
    assign w_full = (r_fill == c_fill_full);

    // Delay line, output register and fill tracking
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_fill  <= '0;
            o_data  <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            // A V wipes its own slot and the three older slots still in flight
            if (w_is_v) begin
                r_s0 <= 1'b0;
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
                r_s3 <= 1'b0;
            end else begin
                r_s0 <= w_mark;
                r_s1 <= r_s0;
                r_s2 <= r_s1;
                r_s3 <= r_s2;
            end
            o_data <= r_s3;
            if (!w_full) begin
                r_fill <= r_fill + FILL_W'(1);
            end
            o_valid <= w_full;
        end
    end

`ifdef HDB3_DECODE_ERR_EN
    localparam logic [FILL_W-1:0] c_zrun_last = FILL_W'(HDB3_RUN - 1);

    logic [FILL_W-1:0] r_zrun;     // consecutive zero symbols, saturating
    logic              r_last_v;   // most recent mark was a V
    logic              w_zero;
    logic              w_err_set;

    assign w_zero = (i_hdb3_code == HDB3_ZERO);

    // Raise an error only once the output is valid, so fill never reports
    assign w_err_set = w_full &&
                       ((i_hdb3_code == HDB3_ILL) ||
                        (w_zero && (r_zrun == c_zrun_last)) ||
                        (w_is_v && r_last_v));

    // Line-code error detection and saturating error counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_zrun    <= '0;
            r_last_v  <= 1'b0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            if (!w_zero) begin
                r_zrun <= '0;
            end else if (r_zrun != c_fill_full) begin
                r_zrun <= r_zrun + FILL_W'(1);
            end
            if (w_mark) begin
                r_last_v <= w_is_v;
            end
            o_err <= w_err_set;
            if (w_err_set && (o_err_cnt != {ERR_CNT_W{1'b1}})) begin
                o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
            end
        end
    end
`else
    assign o_err     = 1'b0;
    assign o_err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdb3_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdb3_decode
//  Description : Directed self-checking bench for hdb3_decode. Expected
//                outputs are hand-computed bit masks: bit k of a mask is the
//                value expected just after the k-th clock edge following
//                reset release. Error expectations follow HDB3_DECODE_ERR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hdb3_decode;
    import hdb3_pkg::*;

    localparam int ERR_CNT_W = 16;
`ifdef HDB3_DECODE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           code;
    logic                 data;
    logic                 valid;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hdb3_decode #(.ERR_CNT_W(ERR_CNT_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_hdb3_code (code),
        .o_data      (data),
        .o_valid     (valid),
        .o_err       (err),
        .o_err_cnt   (err_cnt)
    );

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present one symbol, clock it, then check outputs 1 time unit later
    task automatic step(input string tag, input int k, input logic [1:0] c,
                        input logic ed, input logic ev, input logic ee);
        code = c;
        @(posedge clk);
        #1;
        check($sformatf("%s.data[%0d]", tag, k), 32'(data), 32'(ed));
        check($sformatf("%s.valid[%0d]", tag, k), 32'(valid), 32'(ev));
        check($sformatf("%s.err[%0d]", tag, k), 32'(err), 32'(ee & ERR_EN));
    endtask

    // Hold reset for n edges, checking all outputs are cleared
    task automatic apply_reset(input int n);
        rst  = 1'b1;
        code = HDB3_POS;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst.data[%0d]", i), 32'(data), 32'h0);
            check($sformatf("rst.valid[%0d]", i), 32'(valid), 32'h0);
            check($sformatf("rst.err[%0d]", i), 32'(err), 32'h0);
            check($sformatf("rst.cnt[%0d]", i), 32'(err_cnt), 32'h0);
        end
        rst = 1'b0;
    endtask

    // Run a symbol sequence from reset release; valid expected from edge 4
    task automatic run(input string tag, input logic [1:0] syms[$],
                       input logic [31:0] expd, input logic [31:0] expe);
        for (int k = 0; k < syms.size(); k++) begin
            step(tag, k, syms[k], expd[k], (k >= 4), expe[k]);
        end
    endtask

    logic [1:0] seq[$];

    initial begin
        rst  = 1'b1;
        code = HDB3_ZERO;

        // Reset held for 3 edges with a mark on the line
        apply_reset(3);

        // Alternating marks: every symbol decodes to 1, no errors
        seq = {};
        for (int k = 0; k < 16; k++) seq.push_back((k % 2) ? HDB3_NEG : HDB3_POS);
        run("alt", seq, 32'h0000_FFF0, 32'h0);
        check("alt.cnt", 32'(err_cnt), 32'h0);

        // 000V: + 0 0 0 +(V) then legal alternation
        apply_reset(1);
        seq = '{HDB3_POS, HDB3_ZERO, HDB3_ZERO, HDB3_ZERO, HDB3_POS,
                HDB3_NEG, HDB3_POS, HDB3_NEG, HDB3_POS, HDB3_NEG, HDB3_POS};
        run("z000v", seq, 32'h0000_0610, 32'h0);

        // B00V: + -(B) 0 0 -(V); the B slot must be cleared
        apply_reset(1);
        seq = '{HDB3_POS, HDB3_NEG, HDB3_ZERO, HDB3_ZERO, HDB3_NEG,
                HDB3_POS, HDB3_NEG, HDB3_POS, HDB3_NEG, HDB3_POS, HDB3_NEG};
        run("b00v", seq, 32'h0000_0610, 32'h0);
        check("b00v.cnt", 32'(err_cnt), 32'h0);

        // Illegal code then four zeros: errors after edges 5 and 9
        apply_reset(1);
        seq = '{HDB3_POS, HDB3_NEG, HDB3_POS, HDB3_NEG, HDB3_POS, HDB3_ILL,
                HDB3_ZERO, HDB3_ZERO, HDB3_ZERO, HDB3_ZERO,
                HDB3_NEG, HDB3_POS, HDB3_NEG, HDB3_POS, HDB3_NEG};
        run("err", seq, 32'h0000_41F0, 32'h0000_0220);
        check("err.cnt", 32'(err_cnt), ERR_EN ? 32'h2 : 32'h0);

        // Reset in the middle of a B00V: no stale data, fill restarts,
        // first mark after release (same polarity as before) is not a V
        apply_reset(1);
        step("mid", 0, HDB3_POS,  1'b0, 1'b0, 1'b0);
        step("mid", 1, HDB3_NEG,  1'b0, 1'b0, 1'b0);
        step("mid", 2, HDB3_ZERO, 1'b0, 1'b0, 1'b0);
        apply_reset(1);
        seq = '{HDB3_NEG, HDB3_POS, HDB3_NEG, HDB3_POS, HDB3_NEG, HDB3_POS};
        run("post", seq, 32'h0000_0030, 32'h0);
        check("post.cnt", 32'(err_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
